// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared widths and types for the adder tree stages
package adder_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 16;
  localparam int SUM_W      = DEF_DATA_W + 1;
  localparam logic [DEF_ACC_W-1:0] ACC_MAX = {DEF_ACC_W{1'b1}};

  typedef logic [SUM_W-1:0] sum_t;

endpackage

// File: rtl/stage_fifo2.sv
// rtl/stage_fifo2.sv - 2-entry ready/valid buffer; in_ready is registered so
// upstream never sees a combinational path from out_ready_i
module stage_fifo2 #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             push_o,
  output logic             pop_o
);

  logic [1:0]       cnt_q, cnt_d;
  logic [1:0]       slot;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             rdy_q, rdy_d;

  assign push_o      = in_valid_i && rdy_q;
  assign pop_o       = (cnt_q != 2'd0) && out_ready_i;
  assign in_ready_o  = rdy_q;
  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = head_q;

  // A push lands in the first free slot after any same-cycle pop has shifted.
  assign slot = cnt_q - {1'b0, pop_o};

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q + {1'b0, push_o} - {1'b0, pop_o};
    if (pop_o) begin
      head_d = tail_q;
    end
    if (push_o) begin
      if (slot == 2'd0) begin
        head_d = in_data_i;
      end else begin
        tail_d = in_data_i;
      end
    end
    rdy_d = (cnt_d != 2'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
      rdy_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
      rdy_q  <= rdy_d;
    end
  end

endmodule

// File: rtl/stage3_adder.sv
// rtl/stage3_adder.sv - final adder tree stage: carry-keeping sum, 2-entry
// output buffer, saturating debug accumulator and delivered-result counter
module stage3_adder #(
  parameter int DATA_W = adder_pkg::DEF_DATA_W,
  parameter int ACC_W  = adder_pkg::DEF_ACC_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] p0_reg,
  input  logic [DATA_W-1:0] p1_reg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W:0]   sum_reg,
  output logic              sum_ovf,
  input  logic              acc_clr,
  output logic [ACC_W-1:0]  acc_reg,
  output logic              acc_sat,
  output logic [CNT_W-1:0]  res_cnt
);

  import adder_pkg::*;

  localparam int OUT_W = DATA_W + 1;

  logic [OUT_W-1:0] sum_in;
  logic             push, pop;
  logic [ACC_W-1:0] acc_q, acc_d, acc_base;
  logic [ACC_W:0]   acc_sum;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign sum_in = {1'b0, p0_reg} + {1'b0, p1_reg};

  stage_fifo2 #(
    .WIDTH(OUT_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (sum_in),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (sum_reg),
    .push_o     (push),
    .pop_o      (pop)
  );

  assign sum_ovf = sum_reg[DATA_W];

  // Clear and accept together restart the accumulator from the new beat.
  assign acc_base = acc_clr ? '0 : acc_q;
  assign acc_sum  = {1'b0, acc_base} + {{(ACC_W - DATA_W){1'b0}}, sum_in};

  always_comb begin
    acc_d = acc_q;
    sat_d = sat_q;
    if (push) begin
      acc_d = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
      sat_d = (sat_q && !acc_clr) || acc_sum[ACC_W];
    end else if (acc_clr) begin
      acc_d = '0;
      sat_d = 1'b0;
    end
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, pop};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
      sat_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      sat_q <= sat_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc_reg = acc_q;
  assign acc_sat = sat_q;
  assign res_cnt = cnt_q;

endmodule

// File: tb/tb_stage3_adder.sv
// tb/tb_stage3_adder.sv - self-checking bench for stage3_adder
module tb_stage3_adder;

  localparam int DW = 8;
  localparam int AW = 9;
  localparam int CW = 4;
  localparam int AMAX = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] p0 = '0;
  logic [DW-1:0] p1 = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW:0]   sum_reg;
  logic          sum_ovf;
  logic          acc_clr = 1'b0;
  logic [AW-1:0] acc_reg;
  logic          acc_sat;
  logic [CW-1:0] res_cnt;

  int errors = 0;
  int checks = 0;

  int m_q[$];
  int m_acc;
  bit m_sat;
  int m_cnt;
  bit m_live;

  always #5 clk = ~clk;

  stage3_adder #(.DATA_W(DW), .ACC_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .p0_reg(p0), .p1_reg(p1), .out_valid(out_valid), .out_ready(out_ready),
    .sum_reg(sum_reg), .sum_ovf(sum_ovf), .acc_clr(acc_clr),
    .acc_reg(acc_reg), .acc_sat(acc_sat), .res_cnt(res_cnt)
  );

  task automatic model_reset();
    m_q.delete();
    m_acc  = 0;
    m_sat  = 0;
    m_cnt  = 0;
    m_live = 0;
  endtask

  task automatic tick(input logic iv, input logic [7:0] a, input logic [7:0] b,
                      input logic ordy, input logic clr);
    bit take, give;
    int s, tot;
    in_valid = iv; p0 = a; p1 = b; out_ready = ordy; acc_clr = clr;
    take = iv && m_live && (m_q.size() < 2);
    give = ordy && (m_q.size() > 0);
    s = int'(a) + int'(b);
    @(posedge clk);
    if (give) begin
      void'(m_q.pop_front());
      m_cnt = (m_cnt + 1) % (1 << CW);
    end
    if (take) begin
      m_q.push_back(s);
      tot = (clr ? 0 : m_acc) + s;
      if (tot > AMAX) begin
        m_acc = AMAX;
        m_sat = 1;
      end else begin
        m_acc = tot;
        m_sat = clr ? 0 : m_sat;
      end
    end else if (clr) begin
      m_acc = 0;
      m_sat = 0;
    end
    m_live = 1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    checks++; if (sum_reg !== 9'h000) begin errors++; $display("FAIL rst_sum got %h want 000", sum_reg); end
    checks++; if (sum_ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b want 0", sum_ovf); end
    checks++; if (acc_reg !== 9'h000 || acc_sat !== 1'b0) begin errors++; $display("FAIL rst_acc got %h/%b want 000/0", acc_reg, acc_sat); end
    checks++; if (res_cnt !== 4'h0) begin errors++; $display("FAIL rst_cnt got %h want 0", res_cnt); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL release_in_ready_early got %b want 0", in_ready); end
    tick(0, 8'h00, 8'h00, 0, 0);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    tick(1, 8'h0A, 8'h1A, 1, 0);
    checks++; if (out_valid !== 1'b1 || sum_reg !== 9'h024) begin errors++; $display("FAIL basic_sum got %b/%h want 1/024", out_valid, sum_reg); end
    checks++; if (sum_ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf got %b want 0", sum_ovf); end
    checks++; if (acc_reg !== 9'h024) begin errors++; $display("FAIL basic_acc got %h want 024", acc_reg); end
    tick(0, 8'h00, 8'h00, 1, 0);
    checks++; if (res_cnt !== 4'd1 || out_valid !== 1'b0) begin errors++; $display("FAIL basic_pop got cnt %0d valid %b want 1/0", res_cnt, out_valid); end
  endtask

  task automatic test_carry();
    tick(1, 8'hFF, 8'h02, 1, 0);
    checks++; if (sum_reg !== 9'h101) begin errors++; $display("FAIL carry_sum got %h want 101", sum_reg); end
    checks++; if (sum_ovf !== 1'b1) begin errors++; $display("FAIL carry_ovf got %b want 1", sum_ovf); end
    checks++; if (acc_reg !== 9'h125) begin errors++; $display("FAIL carry_acc got %h want 125", acc_reg); end
    tick(0, 8'h00, 8'h00, 1, 0);
  endtask

  task automatic test_backpressure();
    int c0;
    c0 = m_cnt;
    tick(1, 8'h01, 8'h01, 0, 0);
    tick(1, 8'h02, 8'h02, 0, 0);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b want 0", in_ready); end
    checks++; if (sum_reg !== 9'h002 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_head got %b/%h want 1/002", out_valid, sum_reg); end
    tick(1, 8'h03, 8'h03, 0, 0);
    tick(1, 8'h03, 8'h03, 0, 0);
    checks++; if (sum_reg !== 9'h002 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold got %h/%b want 002/0", sum_reg, in_ready); end
    tick(1, 8'h03, 8'h03, 1, 0);
    checks++; if (sum_reg !== 9'h004 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_pop1 got %h/%b want 004/1", sum_reg, in_ready); end
    tick(1, 8'h03, 8'h03, 1, 0);
    checks++; if (sum_reg !== 9'h006 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_pop2 got %b/%h want 1/006", out_valid, sum_reg); end
    tick(0, 8'h00, 8'h00, 1, 0);
    checks++; if (out_valid !== 1'b0 || res_cnt !== 4'((c0 + 3) % 16)) begin errors++; $display("FAIL bp_drain got %b/%0d want 0/%0d", out_valid, res_cnt, (c0 + 3) % 16); end
    checks++; if (acc_reg !== 9'h131) begin errors++; $display("FAIL bp_acc got %h want 131", acc_reg); end
  endtask

  task automatic test_saturation();
    tick(0, 8'h00, 8'h00, 1, 1);
    checks++; if (acc_reg !== 9'h000 || acc_sat !== 1'b0) begin errors++; $display("FAIL clr_alone got %h/%b want 000/0", acc_reg, acc_sat); end
    tick(1, 8'hFF, 8'h00, 1, 0);
    tick(1, 8'h80, 8'h80, 1, 0);
    checks++; if (acc_reg !== 9'h1FF || acc_sat !== 1'b0) begin errors++; $display("FAIL sat_exact_max got %h/%b want 1FF/0", acc_reg, acc_sat); end
    tick(0, 8'h00, 8'h00, 1, 1);
    tick(1, 8'hFF, 8'hFF, 1, 0);
    checks++; if (acc_reg !== 9'h1FE || acc_sat !== 1'b0) begin errors++; $display("FAIL sat_pre got %h/%b want 1FE/0", acc_reg, acc_sat); end
    tick(1, 8'h01, 8'h01, 1, 0);
    checks++; if (acc_reg !== 9'h1FF || acc_sat !== 1'b1) begin errors++; $display("FAIL sat_clip got %h/%b want 1FF/1", acc_reg, acc_sat); end
    tick(1, 8'h03, 8'h04, 1, 1);
    checks++; if (acc_reg !== 9'h007 || acc_sat !== 1'b0) begin errors++; $display("FAIL clr_accept got %h/%b want 007/0", acc_reg, acc_sat); end
    tick(0, 8'h00, 8'h00, 1, 0);
  endtask

  task automatic test_reset_midstream();
    tick(1, 8'h05, 8'h05, 0, 0);
    tick(1, 8'h06, 8'h06, 0, 0);
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL mid_fill got %b/%b want 0/1", in_ready, out_valid); end
    in_valid = 1'b0; out_ready = 1'b0;
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || res_cnt !== 4'h0) begin errors++; $display("FAIL mid_reset got %b/%0d want 0/0", out_valid, res_cnt); end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick(0, 8'h00, 8'h00, 1, 0);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_release got %b/%b want 0/1", out_valid, in_ready); end
    tick(1, 8'h0A, 8'h1A, 1, 0);
    checks++; if (out_valid !== 1'b1 || sum_reg !== 9'h024) begin errors++; $display("FAIL mid_first got %b/%h want 1/024", out_valid, sum_reg); end
    tick(0, 8'h00, 8'h00, 1, 0);
    checks++; if (res_cnt !== 4'd1 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_replay got %0d/%b want 1/0", res_cnt, out_valid); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
           1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 15) == 0));
      checks++; if (out_valid !== (m_q.size() > 0)) begin errors++; $display("FAIL rnd_valid[%0d] got %b want %b", i, out_valid, m_q.size() > 0); end
      checks++; if (in_ready !== (m_q.size() < 2)) begin errors++; $display("FAIL rnd_ready[%0d] got %b want %b", i, in_ready, m_q.size() < 2); end
      if (m_q.size() > 0) begin
        checks++; if (sum_reg !== 9'(m_q[0]) || sum_ovf !== (m_q[0] > 255)) begin errors++; $display("FAIL rnd_sum[%0d] got %h/%b want %h", i, sum_reg, sum_ovf, m_q[0]); end
      end
      checks++; if (acc_reg !== 9'(m_acc) || acc_sat !== m_sat) begin errors++; $display("FAIL rnd_acc[%0d] got %h/%b want %h/%b", i, acc_reg, acc_sat, m_acc, m_sat); end
      checks++; if (res_cnt !== 4'(m_cnt)) begin errors++; $display("FAIL rnd_cnt[%0d] got %0d want %0d", i, res_cnt, m_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_saturation();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
